// File: rtl/tl_reg_master.sv
// ----------------------------------------------------------------------------
// tl_reg_master
//
// Single-outstanding TileLink-UL master that turns a simple register command
// (read/write, 64-bit data, byte mask) into one A-channel request and returns
// the matching D-channel beat as a response.
//
// Parameters
//   SOURCE_ID  fixed 9-bit TileLink source used on every A request.
//   TIMEOUT    WAIT cycles before the request is abandoned; 0 disables.
//
// Ports
//   clock, reset            sole clock; synchronous active-low reset
//   cmd_*                   command channel (valid/ready, write, addr, data, mask)
//   rsp_*                   response channel (valid/ready, data, error, timeout)
//   busy                    high whenever a transaction is in flight
//   auto_out_a_*            TileLink A channel (request)
//   auto_out_d_*            TileLink D channel (response); param/size/sink ignored
//
// Flow: IDLE -> ACQ -> WAIT -> RESP -> IDLE.
// ----------------------------------------------------------------------------
module tl_reg_master #(
    parameter logic [8:0]  SOURCE_ID = 9'd0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [27:0] cmd_addr,
    input  logic [63:0] cmd_data,
    input  logic [7:0]  cmd_mask,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_error,
    output logic        rsp_timeout,

    output logic        busy,

    output logic        auto_out_a_valid,
    input  logic        auto_out_a_ready,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [2:0]  auto_out_a_bits_param,
    output logic [1:0]  auto_out_a_bits_size,
    output logic [8:0]  auto_out_a_bits_source,
    output logic [27:0] auto_out_a_bits_address,
    output logic [7:0]  auto_out_a_bits_mask,
    output logic [63:0] auto_out_a_bits_data,
    output logic        auto_out_a_bits_corrupt,

    input  logic        auto_out_d_valid,
    output logic        auto_out_d_ready,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [1:0]  auto_out_d_bits_param,
    input  logic [1:0]  auto_out_d_bits_size,
    input  logic [8:0]  auto_out_d_bits_source,
    input  logic        auto_out_d_bits_sink,
    input  logic        auto_out_d_bits_denied,
    input  logic [63:0] auto_out_d_bits_data,
    input  logic        auto_out_d_bits_corrupt
);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpAccessAck  = 3'd0;
    localparam logic [2:0] OpAckData    = 3'd1;

    localparam bit          TimeoutEn   = (TIMEOUT != 0);
    // Last WAIT count value before abort; unused when the timeout is disabled.
    localparam logic [15:0] TimeoutLast = TimeoutEn ? 16'(TIMEOUT - 1) : 16'd0;

    typedef enum logic [1:0] {
        StIdle,
        StAcq,
        StWait,
        StResp
    } state_e;

    state_e      state_q;
    logic        write_q;
    logic [2:0]  a_opcode_q;
    logic [27:0] a_address_q;
    logic [7:0]  a_mask_q;
    logic [63:0] a_data_q;
    logic [15:0] cnt_q;
    logic [63:0] rsp_data_q;
    logic        rsp_error_q;
    logic        rsp_timeout_q;

    logic        d_match;
    logic        d_bad_opcode;

    // D is always drained while out of reset; only a beat for our source in
    // WAIT has any effect.
    assign auto_out_d_ready = reset;
    assign d_match          = auto_out_d_valid && (auto_out_d_bits_source == SOURCE_ID);
    assign d_bad_opcode     = write_q ? (auto_out_d_bits_opcode != OpAccessAck)
                                      : (auto_out_d_bits_opcode != OpAckData);

    // Status flags are gated by reset so they read as idle for the whole
    // time reset is held, including the cycle before the first reset edge.
    assign cmd_ready        = reset && (state_q == StIdle);
    assign auto_out_a_valid = reset && (state_q == StAcq);
    assign rsp_valid        = reset && (state_q == StResp);
    assign busy             = reset && (state_q != StIdle);

    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

    assign auto_out_a_bits_opcode  = a_opcode_q;
    assign auto_out_a_bits_param   = 3'd0;
    assign auto_out_a_bits_size    = 2'd3;
    assign auto_out_a_bits_source  = SOURCE_ID;
    assign auto_out_a_bits_address = a_address_q;
    assign auto_out_a_bits_mask    = a_mask_q;
    assign auto_out_a_bits_data    = a_data_q;
    assign auto_out_a_bits_corrupt = 1'b0;

    logic unused_d_fields;
    assign unused_d_fields = ^{auto_out_d_bits_param, auto_out_d_bits_size,
                               auto_out_d_bits_sink};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StIdle;
            write_q       <= 1'b0;
            a_opcode_q    <= 3'd0;
            a_address_q   <= 28'd0;
            a_mask_q      <= 8'd0;
            a_data_q      <= 64'd0;
            cnt_q         <= 16'd0;
            rsp_data_q    <= 64'd0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        // A fields are fully formed here so they stay frozen in ACQ.
                        write_q     <= cmd_write;
                        a_address_q <= {cmd_addr[27:3], 3'b000};
                        if (cmd_write) begin
                            a_opcode_q <= (cmd_mask == 8'hFF) ? OpPutFull : OpPutPartial;
                            a_mask_q   <= cmd_mask;
                            a_data_q   <= cmd_data;
                        end else begin
                            a_opcode_q <= OpGet;
                            a_mask_q   <= 8'hFF;
                            a_data_q   <= 64'd0;
                        end
                        state_q <= StAcq;
                    end
                end
                StAcq: begin
                    if (auto_out_a_ready) begin
                        cnt_q   <= 16'd0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // A matching beat takes priority over an expiring timeout.
                    if (d_match) begin
                        rsp_data_q    <= write_q ? 64'd0 : auto_out_d_bits_data;
                        rsp_error_q   <= auto_out_d_bits_denied
                                       | (auto_out_d_bits_corrupt & ~write_q)
                                       | d_bad_opcode;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= StResp;
                    end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                        rsp_data_q    <= 64'd0;
                        rsp_error_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_reg_master.sv
// ----------------------------------------------------------------------------
// tb_tl_reg_master
//
// Self-checking bench for tl_reg_master. Each transaction is described at the
// command level (what is asked, how long A is stalled, in which WAIT cycle the
// answer arrives, how long the response is held); expected A fields, response
// timing and response contents are computed from those descriptions.
// ----------------------------------------------------------------------------
module tb_tl_reg_master;

    localparam logic [8:0]  Src = 9'h05A;
    localparam int unsigned To  = 8;

    logic        clock;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [27:0] cmd_addr;
    logic [63:0] cmd_data;
    logic [7:0]  cmd_mask;
    logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [63:0] rsp_data;
    logic        busy;
    logic        a_valid, a_ready, a_corrupt;
    logic [2:0]  a_opcode, a_param;
    logic [1:0]  a_size;
    logic [8:0]  a_source;
    logic [27:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid, d_ready, d_sink, d_denied, d_corrupt;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param, d_size;
    logic [8:0]  d_source;
    logic [63:0] d_data;

    tl_reg_master #(
        .SOURCE_ID (Src),
        .TIMEOUT   (To)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_write               (cmd_write),
        .cmd_addr                (cmd_addr),
        .cmd_data                (cmd_data),
        .cmd_mask                (cmd_mask),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_data                (rsp_data),
        .rsp_error               (rsp_error),
        .rsp_timeout             (rsp_timeout),
        .busy                    (busy),
        .auto_out_a_valid        (a_valid),
        .auto_out_a_ready        (a_ready),
        .auto_out_a_bits_opcode  (a_opcode),
        .auto_out_a_bits_param   (a_param),
        .auto_out_a_bits_size    (a_size),
        .auto_out_a_bits_source  (a_source),
        .auto_out_a_bits_address (a_address),
        .auto_out_a_bits_mask    (a_mask),
        .auto_out_a_bits_data    (a_data),
        .auto_out_a_bits_corrupt (a_corrupt),
        .auto_out_d_valid        (d_valid),
        .auto_out_d_ready        (d_ready),
        .auto_out_d_bits_opcode  (d_opcode),
        .auto_out_d_bits_param   (d_param),
        .auto_out_d_bits_size    (d_size),
        .auto_out_d_bits_source  (d_source),
        .auto_out_d_bits_sink    (d_sink),
        .auto_out_d_bits_denied  (d_denied),
        .auto_out_d_bits_data    (d_data),
        .auto_out_d_bits_corrupt (d_corrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic d_idle();
        d_valid   = 1'b0;
        d_source  = 9'd0;
        d_opcode  = 3'd0;
        d_param   = 2'd0;
        d_size    = 2'd0;
        d_sink    = 1'b0;
        d_denied  = 1'b0;
        d_corrupt = 1'b0;
        d_data    = 64'd0;
    endtask

    task automatic d_beat(input logic [8:0] src, input logic [2:0] op, input bit den,
                          input bit cor, input logic [63:0] data);
        d_valid   = 1'b1;
        d_source  = src;
        d_opcode  = op;
        d_param   = 2'($urandom_range(3, 0));
        d_size    = 2'($urandom_range(3, 0));
        d_sink    = 1'($urandom_range(1, 0));
        d_denied  = den;
        d_corrupt = cor;
        d_data    = data;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_a_valid"},   64'(a_valid),   64'd0);
    endtask

    // One complete transaction. j is the WAIT cycle (0-based) carrying the
    // matching D beat; any j beyond the timeout window means no answer.
    task automatic run_txn(input bit wr, input logic [27:0] addr, input logic [63:0] data,
                           input logic [7:0] mask, input int a_delay, input int j,
                           input bit noise, input int r_delay, input logic [63:0] dd,
                           input logic [2:0] dop, input bit dden, input bit dcor);
        logic [2:0]  e_op;
        logic [7:0]  e_mask;
        logic [63:0] e_data, e_rdata;
        logic [27:0] e_addr;
        logic        e_err, e_to;
        int          last;
        logic [8:0]  bad_src;

        e_op   = wr ? ((mask == 8'hFF) ? 3'd0 : 3'd1) : 3'd4;
        e_mask = wr ? mask : 8'hFF;
        e_data = wr ? data : 64'd0;
        e_addr = addr & ~28'h7;
        e_to   = (j > int'(To) - 1);
        last   = e_to ? int'(To) - 1 : j;
        if (e_to) begin
            e_rdata = 64'd0;
            e_err   = 1'b1;
        end else begin
            e_rdata = wr ? 64'd0 : dd;
            e_err   = dden | (dcor & ~wr) | (dop != (wr ? 3'd0 : 3'd1));
        end

        @(negedge clock);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_mask  = mask;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_data  = ~data;

        for (int k = 0; k <= a_delay; k++) begin
            check("acq_a_valid",   64'(a_valid),   64'd1);
            check("acq_opcode",    64'(a_opcode),  64'(e_op));
            check("acq_address",   64'(a_address), 64'(e_addr));
            check("acq_mask",      64'(a_mask),    64'(e_mask));
            check("acq_data",      a_data,         e_data);
            check("acq_source",    64'(a_source),  64'(Src));
            check("acq_size",      64'(a_size),    64'd3);
            check("acq_param",     64'(a_param),   64'd0);
            check("acq_corrupt",   64'(a_corrupt), 64'd0);
            check("acq_cmd_ready", 64'(cmd_ready), 64'd0);
            check("acq_busy",      64'(busy),      64'd1);
            a_ready = (k == a_delay);
            @(negedge clock);
        end
        a_ready = 1'b0;

        for (int i = 0; i <= last; i++) begin
            check("wait_a_valid",   64'(a_valid),   64'd0);
            check("wait_rsp_valid", 64'(rsp_valid), 64'd0);
            check("wait_d_ready",   64'(d_ready),   64'd1);
            if (i == j) begin
                d_beat(Src, dop, dden, dcor, dd);
            end else if (noise && ($urandom_range(1, 0) == 1)) begin
                bad_src = (i == 0) ? Src + 9'd1 : 9'($urandom);
                if (bad_src == Src) bad_src = Src + 9'd1;
                d_beat(bad_src, 3'($urandom), 1'b0, 1'b0, {$urandom, $urandom});
            end else begin
                d_idle();
            end
            @(negedge clock);
        end
        d_idle();

        for (int k = 0; k <= r_delay; k++) begin
            check("resp_valid",     64'(rsp_valid),   64'd1);
            check("resp_data",      rsp_data,         e_rdata);
            check("resp_error",     64'(rsp_error),   64'(e_err));
            check("resp_timeout",   64'(rsp_timeout), 64'(e_to));
            check("resp_cmd_ready", 64'(cmd_ready),   64'd0);
            check("resp_busy",      64'(busy),        64'd1);
            // A command offered while the response is pending must be ignored.
            cmd_valid = noise;
            cmd_write = 1'b1;
            rsp_ready = (k == r_delay);
            @(negedge clock);
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check_idle("post");
    endtask

    task automatic drain_late_beat(input string tag);
        @(negedge clock);
        d_beat(Src, 3'd1, 1'b0, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0);
        @(negedge clock);
        d_idle();
        check_idle(tag);
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 28'd0;
        cmd_data  = 64'd0;
        cmd_mask  = 8'd0;
        rsp_ready = 1'b0;
        a_ready   = 1'b0;
        d_idle();

        repeat (3) @(negedge clock);
        check("rst_cmd_ready",   64'(cmd_ready),   64'd0);
        check("rst_a_valid",     64'(a_valid),     64'd0);
        check("rst_rsp_valid",   64'(rsp_valid),   64'd0);
        check("rst_busy",        64'(busy),        64'd0);
        check("rst_d_ready",     64'(d_ready),     64'd0);
        check("rst_rsp_data",    rsp_data,         64'd0);
        check("rst_rsp_error",   64'(rsp_error),   64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        reset = 1'b1;

        // Directed read with immediate handshakes: response on cycle 3.
        run_txn(1'b0, 28'h0C00004, 64'h1111, 8'h00, 0, 0, 1'b0, 0,
                64'hDEAD_BEEF_0000_0007, 3'd1, 1'b0, 1'b0);
        // Partial and full writes.
        run_txn(1'b1, 28'h0000123, 64'hCAFE_F00D_1234_5678, 8'h0F, 0, 0, 1'b0, 0,
                64'h5555, 3'd0, 1'b0, 1'b0);
        run_txn(1'b1, 28'h0ABCDEF, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 1'b0, 0,
                64'h0, 3'd0, 1'b0, 1'b0);
        // A stalled 5 cycles, wrong-source beat first, then a denied answer.
        run_txn(1'b0, 28'h0000040, 64'h0, 8'h00, 5, 3, 1'b1, 0,
                64'h7777, 3'd1, 1'b1, 1'b0);
        // Beat arriving in the last WAIT cycle beats the timeout.
        run_txn(1'b0, 28'h0000048, 64'h0, 8'h00, 0, int'(To) - 1, 1'b0, 0,
                64'h8888_9999, 3'd1, 1'b0, 1'b0);
        // No answer: timeout, then a late beat drains and the next read works.
        run_txn(1'b0, 28'h0000050, 64'h0, 8'h00, 1, 1000, 1'b1, 1,
                64'h0, 3'd1, 1'b0, 1'b0);
        drain_late_beat("drain_timeout");
        run_txn(1'b0, 28'h0000058, 64'h0, 8'h00, 0, 1, 1'b0, 0,
                64'hABCD_0000_0000_ABCD, 3'd1, 1'b0, 1'b0);

        // Reset pulse while in WAIT abandons the transaction.
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 28'h0000060;
        @(negedge clock);
        cmd_valid = 1'b0;
        a_ready   = 1'b1;
        @(negedge clock);
        a_ready = 1'b0;
        check("wait_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_cmd_ready",   64'(cmd_ready),   64'd0);
        check("midrst_a_valid",     64'(a_valid),     64'd0);
        check("midrst_rsp_valid",   64'(rsp_valid),   64'd0);
        check("midrst_busy",        64'(busy),        64'd0);
        check("midrst_d_ready",     64'(d_ready),     64'd0);
        check("midrst_rsp_data",    rsp_data,         64'd0);
        check("midrst_rsp_error",   64'(rsp_error),   64'd0);
        check("midrst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        reset = 1'b1;
        drain_late_beat("drain_reset");
        // Response held 3 cycles with a command offered meanwhile.
        run_txn(1'b1, 28'h0000068, 64'hFEED_FACE_0BAD_F00D, 8'hA5, 0, 0, 1'b1, 3,
                64'h0, 3'd0, 1'b0, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            bit          wr;
            logic [7:0]  mask;
            logic [2:0]  dop;
            wr   = 1'($urandom_range(1, 0));
            mask = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(5, 0) == 0) dop = 3'($urandom);
            else                           dop = wr ? 3'd0 : 3'd1;
            run_txn(wr, 28'($urandom), {$urandom, $urandom}, mask,
                    int'($urandom_range(3, 0)), int'($urandom_range(10, 0)),
                    1'($urandom_range(1, 0)), int'($urandom_range(2, 0)),
                    {$urandom, $urandom}, dop,
                    ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
